collision_probe_arbiter: RTL
============================

Name: collision_probe_arbiter

Overview:
Shares the single-port, 1-cycle-latency collision map ROM (640x480 pixels, 3-bit material code per pixel, address = y*640 + x) between the two character controllers (requester 0 = Fireboy, requester 1 = Watergirl). On each granted request the block probes the 4 corners of the requester's proposed hitbox and returns an 8-bit one-hot-OR mask of the material codes touched. It sits between the per-character movement FSMs and the collision ROM.

Parameters:
BOX_W, 16, hitbox width in pixels (>=1)
BOX_H, 24, hitbox height in pixels (>=1)
SCR_W, 640, map width; also the row stride of the address
SCR_H, 480, map height
OOB_CODE, 1, material code reported for a corner outside the map (1 = wall)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
req  in  2  per-requester request; level, held until own done bit pulses
req_x  in  20  {x1[9:0], x0[9:0]}, proposed hitbox top-left x per requester
req_y  in  18  {y1[8:0], y0[8:0]}, proposed hitbox top-left y per requester
done  out  2  one-cycle pulse to the granted requester; result valid this cycle
hit_mask  out  8  bit c set if any probed corner has code c; valid while done!=0
busy  out  1  high from grant cycle through done cycle
rom_addr  out  19  collision ROM address
rom_q  in  3  collision ROM data, valid the cycle after rom_addr is sampled

Behaviour:
- Reset (synchronous, any state): state=IDLE, done=0, hit_mask=0, busy=0, rom_addr=0, rr_last=1 (requester 0 wins the first tie), probe counter=0, accumulator=0.
- States: IDLE, PROBE, DRAIN, DONE.
- IDLE: if req!=0, grant per round-robin (both high -> requester != rr_last; one high -> that one). Latch the granted x,y; set rr_last=grant; clear accumulator; busy=1 from the next cycle; go PROBE with k=0. Grant cycle = A.
- PROBE (cycles A+1..A+4, k=0..3): corner k = (x + (k[0]?BOX_W-1:0), y + (k[1]?BOX_H-1:0)). Compute in 11 bits. Corner is OOB if cx>=SCR_W or cy>=SCR_H. rom_addr = cy*SCR_W+cx (combinational from latched coords and k), or 0 if OOB. Push the OOB flag into a 1-deep pipeline aligned with ROM latency. From k>=1, fold the previous corner into the accumulator: acc |= 1<<(oob_d ? OOB_CODE : rom_q). After k=3 go DRAIN.
- DRAIN (A+5): fold corner 3 the same way; rom_addr=0; go DONE.
- DONE (A+6): done[grant]=1 for exactly this cycle; hit_mask=acc (registered, held until the next DONE or reset); busy=1; next state IDLE. A new grant is possible in IDLE at A+7 at the earliest.
- Request-to-done latency is fixed at 6 cycles after the grant cycle. Throughput is 1 request per 7 cycles.
- A requester dropping req mid-operation does not abort: the sequence completes and done still pulses. Coordinate changes after grant are ignored.
- A requester still asserting req after its done is eligible again. If the other requester is also asserting, the other requester wins, so neither starves.
- rom_addr is 0 in IDLE, DRAIN and DONE. Max in-range address = 479*640+639 = 307199, which fits in 19 bits.
- A mid-operation reset discards the accumulator. No done is issued for the aborted request.

Test Plan:
- Reset, then req=01, x0=100, y0=50; ROM all code 0 -> rom_addr seq 32100, 32115, 46820, 46835 in cycles A+1..A+4; done=01 at A+6; hit_mask=0x01; busy low at A+7.
- Same box, ROM pixel 46835 = code 3 (others 0) -> hit_mask=0x09 at done.
- req=11 held continuously from reset -> grants alternate 0,1,0,1; done pulses at A+6, A+13, A+20, A+27 alternating 01/10; each grant's rom_addr uses that requester's coordinates.
- req=10, x1=630, y1=470 -> corners 1, 2, 3 OOB (x 645>639, y 493>479); rom_addr = 301430, 0, 0, 0; ROM code 2 at 301430 -> hit_mask=0x06.
- Assert reset at A+3 during PROBE -> next cycle IDLE, done=0, busy=0, hit_mask=0, rom_addr=0; no done for the aborted request; req=01 again -> full normal sequence.
- req=01 dropped at A+2 -> done=01 still pulses at A+6, then block idles with busy=0.

Source files
------------

// File: rtl/collision_probe_arbiter.sv
// Shares the single-port collision ROM between two character controllers:
// round-robin grant, four hitbox-corner probes, one-hot material mask result.
module collision_probe_arbiter #(
    parameter int BOX_W    = 16,
    parameter int BOX_H    = 24,
    parameter int SCR_W    = 640,
    parameter int SCR_H    = 480,
    parameter int OOB_CODE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [19:0] req_x,
    input  logic [17:0] req_y,
    output logic [1:0]  done,
    output logic [7:0]  hit_mask,
    output logic        busy,
    output logic [18:0] rom_addr,
    input  logic [2:0]  rom_q
);

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DRAIN, S_DONE} state_t;

    state_t      state;
    logic        rr_last;
    logic        gnt;
    logic        pick;
    logic [1:0]  k;
    logic [9:0]  lat_x;
    logic [8:0]  lat_y;
    logic        oob_d;
    logic [7:0]  acc;
    logic [7:0]  acc_next;
    logic [10:0] cx;
    logic [10:0] cy;
    logic        corner_oob;
    logic [2:0]  fold_code;

    // Both requesting: the one that did not win last time; otherwise the sole requester.
    always_comb pick = (req == 2'b11) ? ~rr_last : req[1];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        rom_addr   = '0;
        cx         = {1'b0, lat_x} + (k[0] ? 11'(BOX_W - 1) : 11'd0);
        cy         = {2'b0, lat_y} + (k[1] ? 11'(BOX_H - 1) : 11'd0);
        corner_oob = (cx >= 11'(SCR_W)) || (cy >= 11'(SCR_H));
        if (state == S_PROBE && !corner_oob)
            rom_addr = 19'(cy) * 19'(SCR_W) + 19'(cx);
    end

    // rom_q belongs to the corner presented one cycle earlier; oob_d is its matching flag.
    always_comb begin
        fold_code = oob_d ? 3'(OOB_CODE) : rom_q;
        acc_next  = acc | (8'd1 << fold_code);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            done     <= '0;
            hit_mask <= '0;
            busy     <= 1'b0;
            rr_last  <= 1'b1;
            gnt      <= 1'b0;
            k        <= '0;
            lat_x    <= '0;
            lat_y    <= '0;
            oob_d    <= 1'b0;
            acc      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        gnt     <= pick;
                        rr_last <= pick;
                        lat_x   <= pick ? req_x[19:10] : req_x[9:0];
                        lat_y   <= pick ? req_y[17:9]  : req_y[8:0];
                        acc     <= '0;
                        busy    <= 1'b1;
                        k       <= '0;
                        state   <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    oob_d <= corner_oob;
                    if (k != 2'd0)
                        acc <= acc_next;
                    k <= k + 2'd1;
                    if (k == 2'd3)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    acc      <= acc_next;
                    hit_mask <= acc_next;
                    done     <= gnt ? 2'b10 : 2'b01;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
